// File: rtl/demux_1x2_stream.sv
// Registered 1-to-2 stream demultiplexer with a one-entry buffer per output.
// Define DEMUX_PKT_LOCK_EN to hold the route from a packet's first beat through its last beat.
module demux_1x2_stream #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   input  logic             in_last,
   output logic             in_ready,
   input  logic             sel,
   output logic [WIDTH-1:0] out0_data,
   output logic             out0_valid,
   output logic             out0_last,
   input  logic             out0_ready,
   output logic [WIDTH-1:0] out1_data,
   output logic             out1_valid,
   output logic             out1_last,
   input  logic             out1_ready
);

   logic route;
   logic free0, free1;
   logic accept;
   logic load0, load1;

`ifdef DEMUX_PKT_LOCK_EN
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOCK0 = 2'd1,
      LOCK1 = 2'd2
   } state_t;

   state_t state, state_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      route = sel;
      case (state)
         LOCK0:   route = 1'b0;
         LOCK1:   route = 1'b1;
         default: route = sel;
      endcase
   end

   always_comb begin
      state_nxt = state;
      if (accept) begin
         if (in_last) begin
            state_nxt = IDLE;
         end else if (state == IDLE) begin
            state_nxt = route ? LOCK1 : LOCK0;
         end
      end
   end
`else
   assign route = sel;
`endif

   // A buffer draining this cycle can take a new beat in the same edge.
   assign free0    = !out0_valid || out0_ready;
   assign free1    = !out1_valid || out1_ready;
   assign in_ready = !rst && (route ? free1 : free0);
   assign accept   = in_valid && in_ready;
   assign load0    = accept && !route;
   assign load1    = accept && route;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out0_valid <= 1'b0;
         out0_data  <= '0;
         out0_last  <= 1'b0;
      end else if (load0) begin
         out0_valid <= 1'b1;
         out0_data  <= in_data;
         out0_last  <= in_last;
      end else if (out0_ready) begin
         out0_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out1_valid <= 1'b0;
         out1_data  <= '0;
         out1_last  <= 1'b0;
      end else if (load1) begin
         out1_valid <= 1'b1;
         out1_data  <= in_data;
         out1_last  <= in_last;
      end else if (out1_ready) begin
         out1_valid <= 1'b0;
      end
   end

endmodule

// File: doc/demux_1x2_stream.md
# demux_1x2_stream

- Registered 1-to-2 stream demultiplexer: the inverse of the team's 2:1 select mux.
- Accepts one valid/ready input stream and steers each beat to output channel 0 or 1 according to `sel`.
- In packet-lock mode, the route is held from a packet's first beat through its `in_last` beat.
- Sits between a shared producer and two independent consumers. Each output has a one-entry register buffer for timing isolation.

## Interface
- `WIDTH`, default 8: data width in bits.
- `clk` input, 1 bit: single clock, rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `in_data` input, WIDTH bits: input beat payload.
- `in_valid` input, 1 bit: input beat present.
- `in_last` input, 1 bit: marks the final beat of a packet.
- `in_ready` output, 1 bit: input beat accepted when `in_valid && in_ready` at the clock edge.
- `sel` input, 1 bit: route select (0 → channel 0, 1 → channel 1).
- `out0_data` output, WIDTH bits: channel 0 payload.
- `out0_valid` output, 1 bit: channel 0 beat present.
- `out0_last` output, 1 bit: channel 0 end of packet.
- `out0_ready` input, 1 bit: channel 0 consumer accepts.
- `out1_data`, `out1_valid`, `out1_last`, `out1_ready`: identical to channel 0, for channel 1.

## Operation
- Each channel has a one-entry buffer holding data, last and valid. A channel is "free" when `outN_valid == 0` or `outN_ready == 1` in the current cycle.
- Route state machine has three states: IDLE, LOCK0, LOCK1.
  - IDLE: effective route = `sel`.
  - LOCK0 / LOCK1: effective route = 0 / 1, and `sel` is ignored.
- `in_ready` = the effective-route channel is free, and `rst` is low. It is combinational from `outN_valid`, `outN_ready`, `sel` and the state. It never depends on `in_valid`.
- On acceptance:
  - The beat loads into the effective-route buffer.
  - That channel's `valid` becomes 1 next cycle.
- A channel buffer clears (`valid` → 0) when `outN_valid && outN_ready` and no new beat loads into it in the same cycle.
- Simultaneous drain and load on the same channel: the buffer takes the new beat and `valid` stays 1. Full throughput is maintained.
- State transitions:
  - IDLE, accept with `in_last = 0`: go to LOCK`sel`.
  - IDLE, accept with `in_last = 1`: stay IDLE (single-beat packet).
  - LOCKn, accept with `in_last = 1`: go to IDLE.
  - All other cases: hold state.
- The non-selected channel keeps draining independently. A stalled channel blocks only the beats routed to it.
- Outputs never change `data` or `last` while `valid = 1 && ready = 0`.

## Timing
- Latency: 1 cycle from input acceptance edge to `outN_valid = 1`.
- Throughput: 1 beat/cycle when the selected `outN_ready` is held high.
- Reset values:
  - `out0_valid = out1_valid = 0`.
  - `out0_data = out1_data = 0`.
  - `out0_last = out1_last = 0`.
  - State = IDLE.
  - `in_ready = 0` while `rst` is high.
- Reset mid-packet: any partial packet and any buffered beats are discarded, and the state returns to IDLE. The first accepted beat after reset is treated as a packet start.
- Change of `sel` in LOCK state: no effect until the cycle after the `in_last` beat is accepted.
- Change of `sel` in IDLE with `in_valid = 1` and `in_ready = 0`: `in_ready` re-evaluates against the new channel in the same cycle.

## Configuration
- Macro: `DEMUX_PKT_LOCK_EN`.
- Defined:
  - Packet-lock state machine as described above.
  - `in_last` is forwarded to `outN_last`.
- Undefined:
  - No state machine; the effective route is always `sel`, evaluated per beat.
  - `in_last` is still forwarded to `outN_last` unchanged, but has no effect on routing.

## Test plan
- **Reset defaults:** assert `rst` mid-stream with buffers full → all `outN_valid`, `data` and `last` read 0 immediately; `in_ready = 0`; after release, `in_ready = 1` with both outputs ready.
- **Per-beat routing:**
  - Stimulus: `sel = 0` with beat 0x3C, then `sel = 1` with beat 0xA5; both single-beat packets; both readies high.
  - Required: `out0_data = 0x3C`, valid one cycle after acceptance; then `out1_data = 0xA5`, valid on the following cycle.
- **Packet lock:**
  - Stimulus: 3-beat packet 0x01, 0x02, 0x03 (last on 0x03) with `sel = 1` on the first beat, `sel = 0` on beats 2 and 3.
  - Required: all three beats appear on channel 1 and `out1_last = 1` only with 0x03.
  - With `DEMUX_PKT_LOCK_EN` undefined: beats 0x02 and 0x03 appear on channel 0.
- **Backpressure:**
  - Stimulus: `out0_ready = 0` with a beat held in the channel 0 buffer; send to channel 0.
  - Required: `in_ready = 0` and `out0_data` stable; switching `sel = 1` in IDLE gives `in_ready = 1` and the beat reaches channel 1.
- **Full rate:** 16 back-to-back beats 0x00..0x0F to channel 0 with `out0_ready = 1` → `in_ready` stays 1; the outputs appear in order on consecutive cycles with no gaps.
- **Reset mid-packet:**
  - Stimulus: assert `rst` after beat 2 of a 4-beat packet on channel 1; after release send a new beat with `sel = 0`.
  - Required: the new beat goes to channel 0; no stale beat appears on channel 1.
